sample_window_buffer: RTL and testbench
=======================================

SAMPLE_WINDOW_BUFFER -- requirements
Module: sample_window_buffer

Interface
REQ-001 SHALL have parameter N, default 16, meaning signed sample width in bits.
REQ-002 SHALL have parameter M, default 32, meaning buffer depth in samples; legal values are powers of two >= 4.
REQ-003 SHALL have port Clk  input  1  system clock, all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of the buffer occupancy.
REQ-006 SHALL have port in_valid  input  1  in_data holds a sample offered for writing.
REQ-007 SHALL have port in_ready  output  1  the buffer can accept a sample this cycle.
REQ-008 SHALL have port in_data  input  N  signed input sample.
REQ-009 SHALL have port out_valid  output  1  a three-sample window is available.
REQ-010 SHALL have port out_ready  input  1  the consumer accepts the window, advancing it by one sample.
REQ-011 SHALL have port x_prev  output  N  signed oldest sample of the window, x[n-1].
REQ-012 SHALL have port x_cur  output  N  signed middle sample of the window, x[n].
REQ-013 SHALL have port x_next  output  N  signed newest sample of the window, x[n+1].
REQ-014 SHALL have port count  output  $clog2(M)+1  number of stored samples, 0..M.
REQ-015 SHALL have port full  output  1  count == M.
REQ-016 SHALL have port empty  output  1  count == 0.
REQ-017 SHALL have port overrun  output  1  sticky flag: a sample was offered while the buffer was full.

Function
REQ-018 SHALL store samples in an M-entry register array addressed by write pointer wp and read pointer rp, each $clog2(M) bits.
REQ-019 SHALL make wp and rp wrap from M-1 to 0.
REQ-020 SHALL drive in_ready = !full, with no same-cycle bypass on a pop.
REQ-021 SHALL perform a push when in_valid && in_ready: mem[wp] <= in_data, wp <= wp+1.
REQ-022 SHALL drive out_valid = (count >= 3) combinationally from registered count.
REQ-023 SHALL drive the taps combinationally from the array: x_prev = mem[rp], x_cur = mem[rp+1], x_next = mem[rp+2], with addresses taken modulo M.
REQ-024 SHALL perform a pop when out_valid && out_ready: rp <= rp+1, so consecutive windows overlap by two samples.
REQ-025 SHALL handle push and pop in the same cycle: both pointers advance, count unchanged.
REQ-026 SHALL update count on a push only to count+1, on a pop only to count-1, and otherwise hold it.
REQ-027 SHALL make a sample pushed at edge k contribute to count, out_valid and the taps from edge k onward, giving 1-cycle write-to-visible latency.
REQ-028 SHALL ignore out_ready while out_valid is 0: no pointer change, no underflow.
REQ-029 SHALL, on in_valid while full, drop the sample, leave wp and count unchanged, and set overrun to 1 at that edge.
REQ-030 SHALL, on flush == 1, set wp, rp and count to 0 and overrun to 0 at that edge, leaving array contents unchanged.
REQ-031 SHALL give flush priority over a push, a pop and overrun setting in the same cycle.
REQ-032 SHALL NOT let a flush and a push in the same cycle write the array.
REQ-033 SHALL keep tap values unchanged while out_valid is 0 except through pushes; the taps carry no validity meaning then.

Reset
REQ-034 SHALL, while reset == 0, asynchronously force wp = 0, rp = 0, count = 0 and overrun = 0.
REQ-035 SHALL, while reset == 0, asynchronously force every array entry to 0, so that the taps read 0.
REQ-036 SHALL, as a consequence of REQ-034, hold empty = 1, full = 0, in_ready = 1 and out_valid = 0 during reset.
REQ-037 SHALL, on reset asserted mid-operation, discard all stored samples, with no partial push or pop completing.
REQ-038 SHALL accept the first push at the first rising Clk edge after reset deasserts.

Verification (N=16, M=8)
REQ-039 SHALL cover fill: push 10, -20, 30 -> out_valid rises after the third edge; taps = 10, -20, 30; count = 3.
REQ-040 SHALL cover slide: push 40, then pop with out_ready = 1 -> taps = -20, 30, 40; count = 3.
REQ-041 SHALL cover full and overrun: push 8 samples, then offer 99 -> full = 1, in_ready = 0, overrun = 1, count = 8, and 99 is never seen on the taps.
REQ-042 SHALL cover wrap: push and pop continuously for 20 samples 1..20 -> every window equals (k, k+1, k+2) with no discontinuity across the pointer wrap.
REQ-043 SHALL cover simultaneous events: with count = 5, push and pop in the same cycle -> count stays 5; then flush with push and pop -> count = 0, overrun = 0, empty = 1.
REQ-044 SHALL cover reset mid-stream: assert reset with count = 6 -> count = 0 and taps = 0 immediately, without waiting for Clk.

Source files
------------

// File: rtl/sample_window_buffer_if.sv
// Producer/consumer bundle for the sample window buffer: write handshake,
// three-tap window handshake, flush control and occupancy status.
interface sample_window_buffer_if #(
    parameter int N = 16,
    parameter int M = 32
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [N-1:0]      in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [N-1:0]      x_prev;
    logic signed [N-1:0]      x_cur;
    logic signed [N-1:0]      x_next;
    logic [$clog2(M):0]       count;
    logic                     full;
    logic                     empty;
    logic                     overrun;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, x_prev, x_cur, x_next,
               count, full, empty, overrun
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, x_prev, x_cur, x_next,
               count, full, empty, overrun
    );
endinterface

// File: rtl/sample_window_buffer.sv
// Circular sample store presenting an overlapping three-sample window
// (x[n-1], x[n], x[n+1]) that slides by one sample per accepted pop.
module sample_window_buffer #(
    parameter int N = 16,
    parameter int M = 32
) (
    input  logic                   Clk,
    input  logic                   reset,
    sample_window_buffer_if.slave  bus
);
    localparam int AW = $clog2(M);
    localparam int CW = AW + 1;

    logic signed [N-1:0] mem_q [M];
    logic [AW-1:0]       wp_q, wp_d;
    logic [AW-1:0]       rp_q, rp_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overrun_q, overrun_d;

    logic full_w;
    logic out_valid_w;
    logic push_w;
    logic pop_w;

    assign full_w      = (count_q == CW'(M));
    assign out_valid_w = (count_q >= CW'(3));
    assign push_w      = bus.in_valid && !full_w;
    assign pop_w       = out_valid_w && bus.out_ready;

    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (bus.flush) begin
            wp_d      = '0;
            rp_d      = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (push_w) wp_d = wp_q + AW'(1);
            if (pop_w)  rp_d = rp_q + AW'(1);
            if (push_w && !pop_w)      count_d = count_q + CW'(1);
            else if (pop_w && !push_w) count_d = count_q - CW'(1);
            if (bus.in_valid && full_w) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Array is cleared on reset so the taps read zero; a flush only rewinds pointers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < M; i++) mem_q[i] <= '0;
        end else if (push_w && !bus.flush) begin
            mem_q[wp_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = !full_w;
    assign bus.out_valid = out_valid_w;
    assign bus.count     = count_q;
    assign bus.full      = full_w;
    assign bus.empty     = (count_q == '0);
    assign bus.overrun   = overrun_q;
    assign bus.x_prev    = mem_q[rp_q];
    assign bus.x_cur     = mem_q[rp_q + AW'(1)];
    assign bus.x_next    = mem_q[rp_q + AW'(2)];
endmodule

// File: tb/tb_sample_window_buffer.sv
// Self-checking bench: a queue-based reference of the window buffer checked
// every cycle, plus hand-computed literal expectations for key scenarios.
module tb_sample_window_buffer;
    localparam int N = 16;
    localparam int M = 8;

    logic Clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   started = 0;

    int q[$];
    bit m_ovr = 0;

    sample_window_buffer_if #(.N(N), .M(M)) bus ();

    sample_window_buffer #(.N(N), .M(M)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of stored samples, oldest first.
    always @(posedge Clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_ovr = 0;
        end else if (bus.flush) begin
            q.delete();
            m_ovr = 0;
        end else begin
            bit do_push, do_pop;
            do_push = bus.in_valid && (q.size() < M);
            do_pop  = bus.out_ready && (q.size() >= 3);
            if (bus.in_valid && q.size() == M) m_ovr = 1;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(int'(bus.in_data));
        end
    end

    always @(negedge Clk) begin
        if (started) begin
            chk("count",     int'(bus.count),     q.size());
            chk("full",      int'(bus.full),      int'(q.size() == M));
            chk("empty",     int'(bus.empty),     int'(q.size() == 0));
            chk("in_ready",  int'(bus.in_ready),  int'(q.size() < M));
            chk("out_valid", int'(bus.out_valid), int'(q.size() >= 3));
            chk("overrun",   int'(bus.overrun),   int'(m_ovr));
            if (q.size() >= 3) begin
                chk("x_prev", int'(bus.x_prev), q[0]);
                chk("x_cur",  int'(bus.x_cur),  q[1]);
                chk("x_next", int'(bus.x_next), q[2]);
            end
        end
    end

    task automatic cyc(input logic iv, input int d, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = N'(d);
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge Clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        started = 1;
        #2;
        chk("rst_count",    int'(bus.count),     0);
        chk("rst_empty",    int'(bus.empty),     1);
        chk("rst_in_ready", int'(bus.in_ready),  1);
        chk("rst_out_vld",  int'(bus.out_valid), 0);
        chk("rst_x_cur",    int'(bus.x_cur),     0);
        repeat (2) @(posedge Clk);
        #2 reset = 1'b1;
        @(posedge Clk); #1;

        // Fill
        cyc(1, 10, 0, 0);
        cyc(1, -20, 0, 0);
        chk("fill2_out_vld", int'(bus.out_valid), 0);
        cyc(1, 30, 0, 0);
        chk("fill_out_vld", int'(bus.out_valid), 1);
        chk("fill_x_prev",  int'(bus.x_prev),  10);
        chk("fill_x_cur",   int'(bus.x_cur),  -20);
        chk("fill_x_next",  int'(bus.x_next),  30);
        chk("fill_count",   int'(bus.count),    3);

        // Slide
        cyc(1, 40, 0, 0);
        chk("slide_pre_count", int'(bus.count), 4);
        cyc(0, 0, 1, 0);
        chk("slide_x_prev", int'(bus.x_prev), -20);
        chk("slide_x_cur",  int'(bus.x_cur),   30);
        chk("slide_x_next", int'(bus.x_next),  40);
        chk("slide_count",  int'(bus.count),    3);

        // Full and overrun: queue -20,30,40,50,60,70,80,90
        for (int k = 5; k <= 9; k++) cyc(1, k * 10, 0, 0);
        chk("full_flag_pre", int'(bus.full), 1);
        cyc(1, 99, 0, 0);
        chk("ovr_full",     int'(bus.full),     1);
        chk("ovr_in_ready", int'(bus.in_ready), 0);
        chk("ovr_flag",     int'(bus.overrun),  1);
        chk("ovr_count",    int'(bus.count),    8);
        repeat (3) cyc(0, 0, 1, 0);
        chk("drain_x_prev", int'(bus.x_prev), 50);
        chk("drain_count",  int'(bus.count),   5);
        chk("ovr_sticky",   int'(bus.overrun), 1);

        // Simultaneous push+pop, then flush with push+pop
        cyc(1, 100, 1, 0);
        chk("pp_count",  int'(bus.count),  5);
        chk("pp_x_prev", int'(bus.x_prev), 60);
        cyc(1, 101, 1, 1);
        chk("fl_count",   int'(bus.count),   0);
        chk("fl_overrun", int'(bus.overrun), 0);
        chk("fl_empty",   int'(bus.empty),   1);

        // Continuous stream across pointer wrap
        for (int k = 1; k <= 20; k++) begin
            cyc(1, k, 1, 0);
            if (k >= 3) begin
                chk("wrap_x_prev", int'(bus.x_prev), k - 2);
                chk("wrap_x_next", int'(bus.x_next), k);
            end
        end
        chk("wrap_count", int'(bus.count), 3);

        // Reset mid-stream with count = 6
        cyc(0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) cyc(1, k * 7, 0, 0);
        chk("mid_count_pre", int'(bus.count), 6);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_count",  int'(bus.count),     0);
        chk("mid_rst_x_prev", int'(bus.x_prev),    0);
        chk("mid_rst_x_cur",  int'(bus.x_cur),     0);
        chk("mid_rst_x_next", int'(bus.x_next),    0);
        chk("mid_rst_outvld", int'(bus.out_valid), 0);
        @(negedge Clk); #3 reset = 1'b1;
        cyc(1, 5, 0, 0);
        chk("post_rst_count", int'(bus.count), 1);
        @(negedge Clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
